mixed_opcode_dispatch: RTL and testbench
========================================

Name: mixed_opcode_dispatch

Overview:
- Downstream consumer of the opcode tag stream built from the mixed package types (opcodeTagT, opcodeEnumT, OPCODEABASE_*).
- Buffers incoming 9-bit tags and splits each into a command type and a 6-bit index. Legal commands go to the execution stage over a valid/ready interface.
- WAIT tags are consumed locally as timed stalls. Illegal tags are dropped and flagged.
- Keeps per-type statistics readable through a select port.

Parameters:
- DEPTH, 2, input FIFO entries (≥1).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tag_valid  in  1  upstream tag valid.
- tag_ready  out  1  FIFO can accept a tag.
- tag  in  9  opcodeTagT: [8:6] type (opcodeEnumT code), [5:0] index.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  downstream accepts.
- cmd_op  out  3  opcodeEnumT of issued command.
- cmd_idx  out  6  tag[5:0].
- err_pulse  out  1  one-cycle pulse on an illegal tag.
- stat_sel  in  3  statistics select.
- stat_count  out  CNT_W  selected counter, combinational.
- stat_clr  in  1  synchronous clear of all counters.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the owning reset domain):
  - FIFO empty; state RUN; wait_cnt=0; all counters 0.
  - Outputs: cmd_valid=0, cmd_op=0, cmd_idx=0, err_pulse=0, tag_ready=1.
  - A reset mid-STALL or mid-backpressure discards all state.
- Input:
  - Push on tag_valid&&tag_ready.
  - tag_ready = (fifo_count<DEPTH). No combinational path from cmd_ready.
  - When full, no push even if a pop occurs in the same cycle.
- Issue slot free = !cmd_valid || cmd_ready.
- Output registers change only when the slot is free.
- cmd_valid, cmd_op and cmd_idx stay stable while cmd_valid&&!cmd_ready.
- FSM RUN: when the FIFO is non-empty and the slot is free, the head tag is popped and handled by type:
  - type 0,1,3,4 (READ/WRITE/EVICT/TRIM): load cmd_op/cmd_idx, cmd_valid=1.
  - type 2 (WAIT): no command issued. If idx>0: wait_cnt<=idx, go STALL. If idx==0: stay RUN, consumes one cycle only.
  - type 5–7: err_pulse=1 next cycle; error counter +1.
  - With slot free and no new issue, cmd_valid<=0 after a handshake.
- FSM STALL:
  - No pops; FIFO still accepts pushes; a pending cmd is still held until cmd_ready.
  - wait_cnt decrements each cycle. The cycle it equals 1, go RUN.
  - Net effect: exactly idx extra cycles before the next pop.
- Latency/throughput:
  - Tag pushed at edge E0 into an empty FIFO with the slot free gives cmd_valid=1 after E1.
  - One command per cycle sustained with cmd_ready=1.
  - Order is strictly preserved.
- Statistics:
  - Counters saturate at all-ones.
  - stat_sel 0,1,3,4: count of cmd handshakes of that type.
  - stat_sel 2: WAIT tags popped.
  - stat_sel 5: illegal tags.
  - stat_sel 6,7: read 0.
  - stat_clr in the same cycle as an increment: clear wins (result 0).
- err_pulse: one clock wide, back-to-back illegal tags give consecutive pulses.

Test Plan:
- Reset, then tag=0x045 → after E1: cmd_valid=1, cmd_op=1, cmd_idx=5; handshake; stat_sel=1 → 1.
- Back-to-back tags with cmd_ready=1:
  - Baseline: tag=0x083 (WAIT, idx 3) then 0x010 → cmd_op=0, cmd_idx=16 issued exactly 3 cycles later than the same READ without the WAIT.
  - Op 2 never appears on cmd_op; stat_sel=2 → 1.
  - 0x080 (WAIT idx 0) then READ → only one cycle of delay.
- tag=0x1C7 → no cmd_valid; err_pulse high exactly 1 cycle; stat_sel=5 → 1; the following 0x100 issues normally as TRIM idx 0.
- Backpressure, cmd_ready=0:
  - Send 0x000, 0x0C1, 0x101 → first held at the output; FIFO fills; tag_ready=0 after the third push.
  - Assert cmd_ready → READ/0, EVICT/1, TRIM/1 on consecutive cycles; tag_ready=1 after the first pop.
- Reset mid-STALL: tag=0x0BF (WAIT 63), pull rst_n low 10 cycles later → all outputs/counters 0, tag_ready=1; next READ issued with 1-cycle latency.
- stat_clr asserted in the same cycle as a WRITE handshake → stat_sel=1 reads 0 next cycle. Also a counter forced near max must saturate at 0xFFFF, not wrap.

Source files
------------

// File: rtl/mixed_opcode_dispatch_if.sv
// Bundles the tag ingress stream, command egress stream and statistics
// access port of mixed_opcode_dispatch.
interface mixed_opcode_dispatch_if #(
    parameter int CNT_W = 16
);
    logic             tag_valid;
    logic             tag_ready;
    logic [8:0]       tag;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [5:0]       cmd_idx;
    logic             err_pulse;
    logic [2:0]       stat_sel;
    logic [CNT_W-1:0] stat_count;
    logic             stat_clr;

    // Producer of tags, consumer of commands, reader of statistics.
    modport master (
        output tag_valid, tag, cmd_ready, stat_sel, stat_clr,
        input  tag_ready, cmd_valid, cmd_op, cmd_idx, err_pulse, stat_count
    );

    // The dispatcher itself.
    modport slave (
        input  tag_valid, tag, cmd_ready, stat_sel, stat_clr,
        output tag_ready, cmd_valid, cmd_op, cmd_idx, err_pulse, stat_count
    );
endinterface

// File: rtl/mixed_opcode_dispatch.sv
// Buffers 9-bit opcode tags, issues legal commands over valid/ready,
// turns WAIT tags into timed stalls, drops illegal tags and keeps statistics.
module mixed_opcode_dispatch #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mixed_opcode_dispatch_if.slave bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(DEPTH);

    localparam logic [2:0] OP_WAIT = 3'd2;
    localparam logic [2:0] OP_TRIM = 3'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [8:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic              push;
    logic              pop;
    logic [8:0]        head_tag;
    logic [2:0]        head_type;
    logic [5:0]        head_idx;
    logic              head_wait;
    logic              head_bad;

    // Readiness depends only on occupancy, so a full FIFO refuses a tag
    // even when the head leaves in the same cycle.
    assign bus.tag_ready = (fifo_cnt_q < DEPTH_C);
    assign push          = bus.tag_valid && bus.tag_ready;

    assign head_tag  = fifo_mem[rd_ptr_q];
    assign head_type = head_tag[8:6];
    assign head_idx  = head_tag[5:0];
    assign head_wait = (head_type == OP_WAIT);
    assign head_bad  = (head_type > OP_TRIM);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.tag;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Dispatch FSM and output slot
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_op_q, cmd_op_d;
    logic [5:0] cmd_idx_q, cmd_idx_d;
    logic       err_pulse_q, err_pulse_d;
    logic       slot_free;
    logic       cmd_hs;

    assign slot_free = !cmd_valid_q || bus.cmd_ready;
    assign cmd_hs    = cmd_valid_q && bus.cmd_ready;
    assign pop       = (state_q == ST_RUN) && (fifo_cnt_q != '0) && slot_free;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_idx_d   = cmd_idx_q;
        err_pulse_d = 1'b0;

        // A free slot with nothing new to issue retires the previous command.
        if (slot_free) begin
            cmd_valid_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (pop) begin
                    if (head_bad) begin
                        err_pulse_d = 1'b1;
                    end else if (head_wait) begin
                        if (head_idx != 6'd0) begin
                            wait_cnt_d = head_idx;
                            state_d    = ST_STALL;
                        end
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = head_type;
                        cmd_idx_d   = head_idx;
                    end
                end
            end
            ST_STALL: begin
                // Leaving on the count of one yields idx stall cycles in total.
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == 6'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_idx_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_idx_q   <= cmd_idx_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_idx   = cmd_idx_q;
    assign bus.err_pulse = err_pulse_q;

    // ------------------------------------------------------------------
    // Statistics: slots 0,1,3,4 count handshakes, 2 counts WAIT pops,
    // 5 counts illegal tags.
    // ------------------------------------------------------------------
    logic [5:0]            stat_inc;
    logic [5:0][CNT_W-1:0] stat_vec;
    logic [CNT_W-1:0]      stat_mux;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            if (gi == 2) begin : g_inc_wait
                assign stat_inc[gi] = pop && head_wait;
            end else if (gi == 5) begin : g_inc_bad
                assign stat_inc[gi] = pop && head_bad;
            end else begin : g_inc_cmd
                assign stat_inc[gi] = cmd_hs && (cmd_op_q == 3'(gi));
            end

            // Clear takes priority over a coincident increment.
            always_comb begin
                cnt_d = cnt_q;
                if (bus.stat_clr) begin
                    cnt_d = '0;
                end else if (stat_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stat_vec[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        stat_mux = '0;
        case (bus.stat_sel)
            3'd0:    stat_mux = stat_vec[0];
            3'd1:    stat_mux = stat_vec[1];
            3'd2:    stat_mux = stat_vec[2];
            3'd3:    stat_mux = stat_vec[3];
            3'd4:    stat_mux = stat_vec[4];
            3'd5:    stat_mux = stat_vec[5];
            default: stat_mux = '0;
        endcase
    end

    assign bus.stat_count = stat_mux;

endmodule

// File: tb/tb_mixed_opcode_dispatch.sv
// Self-checking bench for mixed_opcode_dispatch: directed scenarios plus a
// randomized run scored against a queue-based model of the tag stream.
`timescale 1ns/1ps
module tb_mixed_opcode_dispatch;
    localparam int CNT_W    = 16;
    localparam int NARROW_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mixed_opcode_dispatch_if #(.CNT_W(CNT_W))    bus ();
    mixed_opcode_dispatch_if #(.CNT_W(NARROW_W)) nbus ();

    mixed_opcode_dispatch #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    mixed_opcode_dispatch #(.DEPTH(2), .CNT_W(NARROW_W)) dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nbus)
    );

    int total = 0;
    int bad   = 0;

    // Monitor: records handshakes as {op,idx}, counts error pulses and
    // checks that a stalled command holds steady.
    logic [8:0] got_q [$];
    int         err_seen = 0;
    int         op2_seen = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_cmd   = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (prev_stall) begin
                    total++;
                    if (!(bus.cmd_valid === 1'b1 && {bus.cmd_op, bus.cmd_idx} === prev_cmd)) begin
                        bad++;
                        $display("FAIL hold_stable: got valid=%0b cmd=%03h, want valid=1 cmd=%03h",
                                 bus.cmd_valid, {bus.cmd_op, bus.cmd_idx}, prev_cmd);
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) begin
                    got_q.push_back({bus.cmd_op, bus.cmd_idx});
                    $display("cmd handshake op=%0d idx=%0d t=%0t", bus.cmd_op, bus.cmd_idx, $time);
                end
                if (bus.cmd_valid && bus.cmd_op == 3'd2) op2_seen++;
                if (bus.err_pulse) err_seen++;
                prev_stall = bus.cmd_valid && !bus.cmd_ready;
                prev_cmd   = {bus.cmd_op, bus.cmd_idx};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (no checks inside) ----------------
    task automatic clear_stats();
        @(negedge clk);
        bus.stat_clr = 1'b1;
        @(negedge clk);
        bus.stat_clr = 1'b0;
    endtask

    // Pushes one or two tags back to back and counts negedges until a
    // command is visible; k = -1 when the bound expires.
    task automatic run_latency(input logic [8:0] first, input bit has_second,
                               input logic [8:0] second, output int k,
                               output logic [8:0] cmd);
        k   = -1;
        cmd = '0;
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = first;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1 && has_second) bus.tag = second;
            else                      bus.tag_valid = 1'b0;
            if (bus.cmd_valid) begin
                k   = c;
                cmd = {bus.cmd_op, bus.cmd_idx};
                break;
            end
        end
        bus.tag_valid = 1'b0;
    endtask

    // Model of issue latency: visible one edge after the push edge, plus one
    // cycle for a WAIT pop and idx further stall cycles.
    function automatic int model_latency(input logic [8:0] first, input bit has_second);
        logic [8:0] t;
        t = first;
        if (has_second && t[8:6] == 3'd2) return 2 + 1 + int'(t[5:0]);
        return 2;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx, bus.err_pulse, bus.tag_ready} !== 12'b0_000_000000_0_1) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b op=%0d idx=%0d err=%0b rdy=%0b, want 0 0 0 0 1",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_idx, bus.err_pulse, bus.tag_ready);
        end
        for (int s = 0; s < 8; s++) begin
            bus.stat_sel = 3'(s);
            #1;
            total++;
            if (bus.stat_count !== '0) begin
                bad++;
                $display("FAIL reset_stat%0d: got %0d want 0", s, bus.stat_count);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.cmd_valid !== 1'b0 || bus.tag_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got v=%0b rdy=%0b want v=0 rdy=1", bus.cmd_valid, bus.tag_ready);
        end
    endtask

    task automatic test_basic_write();
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h045;
        @(negedge clk);
        bus.tag_valid = 1'b0;
        total++;
        if (bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: got valid=%0b want 0", bus.cmd_valid);
        end
        @(negedge clk);
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx} !== {1'b1, 3'd1, 6'd5}) begin
            bad++;
            $display("FAIL basic_issue: got v=%0b op=%0d idx=%0d want 1 1 5",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_idx);
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.stat_sel = 3'd1;
        #1;
        total++;
        if (bus.stat_count !== 16'd1 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_stat: got count=%0d valid=%0b want 1 0", bus.stat_count, bus.cmd_valid);
        end
    endtask

    task automatic test_wait_timing();
        int         k_plain, k_w3, k_w0;
        logic [8:0] c_plain, c_w3, c_w0;
        bus.cmd_ready = 1'b1;
        clear_stats();
        op2_seen = 0;
        run_latency(9'h010, 1'b0, 9'h000, k_plain, c_plain);
        run_latency(9'h083, 1'b1, 9'h010, k_w3, c_w3);
        total++;
        if (k_plain != model_latency(9'h010, 1'b0) || c_plain !== 9'h010) begin
            bad++;
            $display("FAIL wait_plain: got k=%0d cmd=%03h want k=%0d cmd=010", k_plain, c_plain,
                     model_latency(9'h010, 1'b0));
        end
        total++;
        if (k_w3 != model_latency(9'h083, 1'b1) || c_w3 !== 9'h010) begin
            bad++;
            $display("FAIL wait3_latency: got k=%0d cmd=%03h want k=%0d cmd=010", k_w3, c_w3,
                     model_latency(9'h083, 1'b1));
        end
        @(negedge clk);
        bus.stat_sel = 3'd2;
        #1;
        total++;
        if (bus.stat_count !== 16'd1) begin
            bad++;
            $display("FAIL wait_stat: got %0d want 1", bus.stat_count);
        end
        run_latency(9'h080, 1'b1, 9'h010, k_w0, c_w0);
        total++;
        if (k_w0 != k_plain + 1 || c_w0 !== 9'h010) begin
            bad++;
            $display("FAIL wait0_latency: got k=%0d cmd=%03h want k=%0d cmd=010", k_w0, c_w0, k_plain + 1);
        end
        total++;
        if (k_w3 - k_w0 != 3) begin
            bad++;
            $display("FAIL wait_extra: got %0d extra cycles want 3", k_w3 - k_w0);
        end
        @(negedge clk);
        total++;
        if (op2_seen != 0) begin
            bad++;
            $display("FAIL wait_op2: got %0d WAIT commands issued want 0", op2_seen);
        end
    endtask

    task automatic test_illegal();
        logic err_hist [4];
        bus.cmd_ready = 1'b1;
        clear_stats();
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h1C7;
        @(negedge clk);
        bus.tag = 9'h100;
        total++;
        if (bus.err_pulse !== 1'b0 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_early: got err=%0b valid=%0b want 0 0", bus.err_pulse, bus.cmd_valid);
        end
        @(negedge clk);
        bus.tag_valid = 1'b0;
        total++;
        if (bus.err_pulse !== 1'b1 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: got err=%0b valid=%0b want 1 0", bus.err_pulse, bus.cmd_valid);
        end
        @(negedge clk);
        total++;
        if ({bus.err_pulse, bus.cmd_valid, bus.cmd_op, bus.cmd_idx} !== {1'b0, 1'b1, 3'd4, 6'd0}) begin
            bad++;
            $display("FAIL illegal_next: got err=%0b v=%0b op=%0d idx=%0d want 0 1 4 0",
                     bus.err_pulse, bus.cmd_valid, bus.cmd_op, bus.cmd_idx);
        end
        bus.stat_sel = 3'd5;
        #1;
        total++;
        if (bus.stat_count !== 16'd1) begin
            bad++;
            $display("FAIL illegal_stat: got %0d want 1", bus.stat_count);
        end
        // Two illegal tags back to back give two consecutive pulses.
        err_seen = 0;
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h1C7;
        @(negedge clk);
        bus.tag = 9'h1FF;
        err_hist[0] = bus.err_pulse;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            bus.tag_valid = 1'b0;
            err_hist[i] = bus.err_pulse;
        end
        total++;
        if ({err_hist[0], err_hist[1], err_hist[2], err_hist[3]} !== 4'b0110 || err_seen != 2) begin
            bad++;
            $display("FAIL illegal_b2b: got pattern=%0b%0b%0b%0b seen=%0d want 0110 seen=2",
                     err_hist[0], err_hist[1], err_hist[2], err_hist[3], err_seen);
        end
        bus.stat_sel = 3'd5;
        #1;
        total++;
        if (bus.stat_count !== 16'd3) begin
            bad++;
            $display("FAIL illegal_stat3: got %0d want 3", bus.stat_count);
        end
    endtask

    task automatic test_backpressure();
        int base;
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        base = got_q.size();
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h000;
        @(negedge clk);
        bus.tag = 9'h0C1;
        @(negedge clk);
        bus.tag = 9'h101;
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx} !== 10'b1_000_000000) begin
            bad++;
            $display("FAIL bp_first: got v=%0b op=%0d idx=%0d want 1 0 0", bus.cmd_valid, bus.cmd_op, bus.cmd_idx);
        end
        @(negedge clk);
        bus.tag_valid = 1'b0;
        total++;
        if (bus.tag_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: got tag_ready=%0b want 0", bus.tag_ready);
        end
        repeat (2) @(negedge clk);
        total++;
        if (bus.tag_ready !== 1'b0 || {bus.cmd_op, bus.cmd_idx} !== 9'h000) begin
            bad++;
            $display("FAIL bp_hold: got rdy=%0b cmd=%03h want rdy=0 cmd=000", bus.tag_ready, {bus.cmd_op, bus.cmd_idx});
        end
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx} !== {1'b1, 9'h0C1} || bus.tag_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second: got v=%0b cmd=%03h rdy=%0b want 1 0c1 1",
                     bus.cmd_valid, {bus.cmd_op, bus.cmd_idx}, bus.tag_ready);
        end
        @(negedge clk);
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx} !== {1'b1, 9'h101}) begin
            bad++;
            $display("FAIL bp_third: got v=%0b cmd=%03h want 1 101", bus.cmd_valid, {bus.cmd_op, bus.cmd_idx});
        end
        @(negedge clk);
        total++;
        if (bus.cmd_valid !== 1'b0 || got_q.size() != base + 3) begin
            bad++;
            $display("FAIL bp_drain: got valid=%0b handshakes=%0d want 0 3", bus.cmd_valid, got_q.size() - base);
        end else begin
            total++;
            if (got_q[base] !== 9'h000 || got_q[base+1] !== 9'h0C1 || got_q[base+2] !== 9'h101) begin
                bad++;
                $display("FAIL bp_order: got %03h %03h %03h want 000 0c1 101",
                         got_q[base], got_q[base+1], got_q[base+2]);
            end
        end
    endtask

    task automatic test_reset_stall();
        int         k;
        logic [8:0] c;
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h0BF;
        @(negedge clk);
        bus.tag_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.stat_sel = 3'd2;
        #1;
        total++;
        if (bus.stat_count === '0) begin
            bad++;
            $display("FAIL stall_prestat: got %0d want nonzero", bus.stat_count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.cmd_valid, bus.cmd_op, bus.cmd_idx, bus.err_pulse, bus.tag_ready} !== 12'b0_000_000000_0_1) begin
            bad++;
            $display("FAIL stall_reset_out: got v=%0b op=%0d idx=%0d err=%0b rdy=%0b want 0 0 0 0 1",
                     bus.cmd_valid, bus.cmd_op, bus.cmd_idx, bus.err_pulse, bus.tag_ready);
        end
        for (int s = 0; s < 8; s++) begin
            bus.stat_sel = 3'(s);
            #1;
            total++;
            if (bus.stat_count !== '0) begin
                bad++;
                $display("FAIL stall_reset_stat%0d: got %0d want 0", s, bus.stat_count);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_latency(9'h000, 1'b0, 9'h000, k, c);
        total++;
        if (k != model_latency(9'h000, 1'b0) || c !== 9'h000) begin
            bad++;
            $display("FAIL stall_after_reset: got k=%0d cmd=%03h want k=2 cmd=000", k, c);
        end
    endtask

    task automatic test_stat_clr();
        int         k;
        logic [8:0] c;
        clear_stats();
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        bus.tag_valid = 1'b1;
        bus.tag       = 9'h041;
        @(negedge clk);
        bus.tag_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL clr_setup: got valid=%0b want 1", bus.cmd_valid);
        end
        bus.cmd_ready = 1'b1;
        bus.stat_clr  = 1'b1;
        @(negedge clk);
        bus.stat_clr  = 1'b0;
        bus.stat_sel  = 3'd1;
        #1;
        total++;
        if (bus.stat_count !== 16'd0 || bus.cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_wins: got count=%0d valid=%0b want 0 0", bus.stat_count, bus.cmd_valid);
        end
        run_latency(9'h041, 1'b0, 9'h000, k, c);
        @(negedge clk);
        bus.stat_sel = 3'd1;
        #1;
        total++;
        if (bus.stat_count !== 16'd1) begin
            bad++;
            $display("FAIL clr_recount: got %0d want 1", bus.stat_count);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        nbus.cmd_ready = 1'b1;
        nbus.tag_valid = 1'b1;
        nbus.tag       = 9'h000;
        repeat (10) @(negedge clk);
        nbus.stat_sel = 3'd0;
        #1;
        total++;
        if (nbus.stat_count === 4'hF || nbus.stat_count === 4'h0) begin
            bad++;
            $display("FAIL sat_midway: got %0d want between 1 and 14", nbus.stat_count);
        end
        repeat (20) @(negedge clk);
        nbus.tag_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (nbus.stat_count !== 4'hF) begin
            bad++;
            $display("FAIL sat_hold: got %0d want 15", nbus.stat_count);
        end
    endtask

    task automatic test_random();
        localparam int N = 80;
        logic [8:0] tags [N];
        logic [8:0] exp_q [$];
        int         exp_cnt [8];
        int         n_bad;
        int         base;
        int         i;
        int         guard;
        bit         done;

        for (int s = 0; s < 8; s++) exp_cnt[s] = 0;
        n_bad = 0;
        for (int t = 0; t < N; t++) begin
            logic [2:0] ty;
            logic [5:0] ix;
            ty = 3'($urandom_range(0, 7));
            ix = (ty == 3'd2) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            tags[t] = {ty, ix};
            if (ty == 3'd2)      exp_cnt[2]++;
            else if (ty > 3'd4) begin exp_cnt[5]++; n_bad++; end
            else begin exp_cnt[ty]++; exp_q.push_back({ty, ix}); end
        end

        clear_stats();
        @(negedge clk);
        err_seen = 0;
        op2_seen = 0;
        base     = got_q.size();
        i        = 0;
        guard    = 0;
        while (i < N && guard < 5000) begin
            bus.cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                bus.tag_valid = 1'b1;
                bus.tag       = tags[i];
                if (bus.tag_ready) i++;
            end else begin
                bus.tag_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.tag_valid = 1'b0;
        bus.cmd_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (got_q.size() >= base + exp_q.size()) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (10) @(negedge clk);

        total++;
        if (!done || i != N || got_q.size() != base + exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got pushed=%0d handshakes=%0d want %0d %0d",
                     i, got_q.size() - base, N, exp_q.size());
        end else begin
            for (int e = 0; e < exp_q.size(); e++) begin
                total++;
                if (got_q[base+e] !== exp_q[e]) begin
                    bad++;
                    $display("FAIL rand_cmd%0d: got %03h want %03h", e, got_q[base+e], exp_q[e]);
                end
            end
        end
        total++;
        if (err_seen != n_bad || op2_seen != 0) begin
            bad++;
            $display("FAIL rand_err: got err=%0d op2=%0d want %0d 0", err_seen, op2_seen, n_bad);
        end
        for (int s = 0; s < 8; s++) begin
            bus.stat_sel = 3'(s);
            #1;
            total++;
            if (bus.stat_count !== CNT_W'(exp_cnt[s])) begin
                bad++;
                $display("FAIL rand_stat%0d: got %0d want %0d", s, bus.stat_count, exp_cnt[s]);
            end
        end
    endtask

    initial begin
        bus.tag_valid  = 1'b0;
        bus.tag        = '0;
        bus.cmd_ready  = 1'b0;
        bus.stat_sel   = '0;
        bus.stat_clr   = 1'b0;
        nbus.tag_valid = 1'b0;
        nbus.tag       = '0;
        nbus.cmd_ready = 1'b0;
        nbus.stat_sel  = '0;
        nbus.stat_clr  = 1'b0;

        test_reset();
        test_basic_write();
        test_wait_timing();
        test_illegal();
        test_backpressure();
        test_reset_stall();
        test_stat_clr();
        test_saturate();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
